register_tree_pq: RTL and testbench

REGISTER_TREE_PQ -- requirements
Module: register_tree_pq

---
 rtl/register_tree_pq_if.sv | 30 +++
 rtl/register_tree_pq.sv | 158 +++++++++++++++
 tb/tb_register_tree_pq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_tree_pq_if.sv
// Request/response bundle for the register-tree priority queue.
// The master drives requests and the slave returns status and dequeued keys.
interface register_tree_pq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TREE_DEPTH = 3
);
  logic                  i_enqueue;
  logic [DATA_WIDTH-1:0] i_enqueue_value;
  logic                  i_dequeue;
  logic [DATA_WIDTH-1:0] o_dequeue_value;
  logic                  o_dequeue_valid;
  logic [DATA_WIDTH-1:0] o_top;
  logic                  o_top_valid;
  logic                  o_busy;
  logic [TREE_DEPTH:0]   o_count;
  logic                  o_full;
  logic                  o_empty;

  modport master (
    output i_enqueue, i_enqueue_value, i_dequeue,
    input  o_dequeue_value, o_dequeue_valid, o_top,
    input  o_top_valid, o_busy, o_count, o_full, o_empty
  );

  modport slave (
    input  i_enqueue, i_enqueue_value, i_dequeue,
    output o_dequeue_value, o_dequeue_valid, o_top,
    output o_top_valid, o_busy, o_count, o_full, o_empty
  );
endinterface

// File: rtl/register_tree_pq.sv
// Register-tree priority queue: keys live in heap-indexed node registers
// and are re-sorted by alternating even/odd-level compare-swap passes.
module register_tree_pq #(
  parameter int DATA_WIDTH = 32,
  parameter int TREE_DEPTH = 3,
  parameter int MIN_HEAP   = 0
) (
  input logic               clk,
  input logic               rst,
  register_tree_pq_if.slave bus
);
  localparam int CAP   = (1 << TREE_DEPTH) - 1;
  localparam int NPAR  = CAP / 2;
  localparam int SORTS = 2 * (TREE_DEPTH - 1);
  localparam int CW    = TREE_DEPTH + 1;

  typedef logic [DATA_WIDTH-1:0] key_t;
  typedef enum logic [1:0] {
    IDLE,
    SORT_EVEN,
    SORT_ODD
  } state_t;

  key_t                  r_key [CAP];
  logic [CAP-1:0]        r_vld;
  logic [CW-1:0]         r_count;
  state_t                r_state;
  logic [3:0]            r_scnt;
  key_t                  r_deq_value;
  logic                  r_deq_valid;

  key_t                  w_key [CAP];
  logic [CAP-1:0]        w_vld;
  logic [NPAR-1:0]       w_lb;
  logic [NPAR-1:0]       w_rb;
  logic [NPAR-1:0]       w_rl;
  logic [TREE_DEPTH-1:0] w_tail;
  logic [TREE_DEPTH-1:0] w_last;
  logic                  w_empty;
  logic                  w_full;

  function automatic logic beats(
    input key_t kc, input logic vc,
    input key_t kp, input logic vp
  );
    logic w;
    w = (MIN_HEAP != 0) ? (kc < kp) : (kc > kp);
    return vc && (!vp || w);
  endfunction

  function automatic int lvl(input int idx);
    int n;
    int l;
    n = idx + 1;
    l = 0;
    while (n > 1) begin
      n = n >> 1;
      l++;
    end
    return l;
  endfunction

  assign w_tail  = r_count[TREE_DEPTH-1:0];
  assign w_last  = w_tail - TREE_DEPTH'(1);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(CAP));

  always_comb begin
    w_lb = '0;
    w_rb = '0;
    w_rl = '0;
    for (int p = 0; p < NPAR; p++) begin
      w_lb[p] = beats(r_key[2*p+1], r_vld[2*p+1],
                      r_key[p], r_vld[p]);
      w_rb[p] = beats(r_key[2*p+2], r_vld[2*p+2],
                      r_key[p], r_vld[p]);
      w_rl[p] = beats(r_key[2*p+2], 1'b1,
                      r_key[2*p+1], 1'b1);
    end
  end

  // Triples of one level parity are disjoint, so all swaps are concurrent.
  always_comb begin
    w_key = r_key;
    w_vld = r_vld;
    for (int p = 0; p < NPAR; p++) begin
      if ((lvl(p) % 2 == 1) == (r_state == SORT_ODD)) begin
        if (w_lb[p] && !(w_rb[p] && w_rl[p])) begin
          w_key[p]     = r_key[2*p+1];
          w_key[2*p+1] = r_key[p];
          w_vld[p]     = r_vld[2*p+1];
          w_vld[2*p+1] = r_vld[p];
        end else if (w_rb[p]) begin
          w_key[p]     = r_key[2*p+2];
          w_key[2*p+2] = r_key[p];
          w_vld[p]     = r_vld[2*p+2];
          w_vld[2*p+2] = r_vld[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAP; i++) r_key[i] <= '0;
      r_vld       <= '0;
      r_count     <= '0;
      r_state     <= IDLE;
      r_scnt      <= '0;
      r_deq_value <= '0;
      r_deq_valid <= 1'b0;
    end else begin
      r_deq_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_scnt <= '0;
          if (bus.i_dequeue && !w_empty) begin
            r_deq_value <= r_key[0];
            r_deq_valid <= 1'b1;
            r_state     <= SORT_EVEN;
            if (bus.i_enqueue) begin
              r_key[0] <= bus.i_enqueue_value;
            end else begin
              r_key[0]      <= r_key[w_last];
              r_vld[w_last] <= 1'b0;
              r_count       <= r_count - CW'(1);
            end
          end else if (bus.i_enqueue && !w_full) begin
            r_key[w_tail] <= bus.i_enqueue_value;
            r_vld[w_tail] <= 1'b1;
            r_count       <= r_count + CW'(1);
            r_state       <= SORT_EVEN;
          end
        end
        SORT_EVEN, SORT_ODD: begin
          r_key <= w_key;
          r_vld <= w_vld;
          if (r_scnt == 4'(SORTS - 1)) begin
            r_state <= IDLE;
          end else begin
            r_scnt  <= r_scnt + 4'd1;
            r_state <= (r_state == SORT_EVEN) ? SORT_ODD : SORT_EVEN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_dequeue_value = r_deq_value;
  assign bus.o_dequeue_valid = r_deq_valid;
  assign bus.o_top           = r_key[0];
  assign bus.o_top_valid     = (r_state == IDLE) && !w_empty;
  assign bus.o_busy          = (r_state != IDLE);
  assign bus.o_count         = r_count;
  assign bus.o_full          = w_full;
  assign bus.o_empty         = w_empty;
endmodule

// File: tb/tb_register_tree_pq.sv
// Scoreboard bench for register_tree_pq: a max-heap and a min-heap instance
// driven with directed vectors; dequeued keys are checked by monitors.
module tb_register_tree_pq;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  register_tree_pq_if #(.DATA_WIDTH(32), .TREE_DEPTH(3)) ifa ();
  register_tree_pq_if #(.DATA_WIDTH(32), .TREE_DEPTH(3)) ifb ();

  register_tree_pq #(
    .DATA_WIDTH(32), .TREE_DEPTH(3), .MIN_HEAP(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave)
  );

  register_tree_pq #(
    .DATA_WIDTH(32), .TREE_DEPTH(3), .MIN_HEAP(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.o_dequeue_valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL deq_a_unexpected: got %h, expected no pulse",
                 ifa.o_dequeue_value);
      end else begin
        chk("deq_a", ifa.o_dequeue_value, qa.pop_front());
      end
    end
    if (ifb.o_dequeue_valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL deq_b_unexpected: got %h, expected no pulse",
                 ifb.o_dequeue_value);
      end else begin
        chk("deq_b", ifb.o_dequeue_value, qb.pop_front());
      end
    end
  end

  task automatic drive(input bit sel, input bit e, input bit d,
                       input logic [31:0] v);
    if (sel) begin
      ifb.i_enqueue       = e;
      ifb.i_dequeue       = d;
      ifb.i_enqueue_value = v;
    end else begin
      ifa.i_enqueue       = e;
      ifa.i_dequeue       = d;
      ifa.i_enqueue_value = v;
    end
  endtask

  function automatic logic busy(input bit sel);
    return sel ? ifb.o_busy : ifa.o_busy;
  endfunction

  task automatic wait_idle(input bit sel, output int lat);
    lat = 0;
    while (busy(sel) !== 1'b0 && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // One request held for a single edge, then wait until idle again.
  task automatic op(input bit sel, input bit e, input bit d,
                    input logic [31:0] v, input int exp_lat);
    int lat;
    @(negedge clk);
    drive(sel, e, d, v);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0);
    wait_idle(sel, lat);
    chk(sel ? "latency_b" : "latency_a", 32'(lat), 32'(exp_lat));
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  initial begin
    int lat;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    chk("rst_count", 32'(ifa.o_count), 32'd0);
    chk("rst_empty", 32'(ifa.o_empty), 32'd1);
    chk("rst_full", 32'(ifa.o_full), 32'd0);
    chk("rst_busy", 32'(ifa.o_busy), 32'd0);
    chk("rst_topv", 32'(ifa.o_top_valid), 32'd0);
    chk("rst_deqv", 32'(ifa.o_dequeue_valid), 32'd0);

    // Basic ordering on the max heap.
    op(0, 1, 0, 32'h10, 4);
    op(0, 1, 0, 32'h20, 4);
    op(0, 1, 0, 32'h30, 4);
    chk("top_30", ifa.o_top, 32'h30);
    chk("count_3", 32'(ifa.o_count), 32'd3);
    chk("topv_3", 32'(ifa.o_top_valid), 32'd1);
    qa.push_back(32'h30);
    op(0, 0, 1, 32'h0, 4);
    chk("top_after_deq", ifa.o_top, 32'h20);
    qa.push_back(32'h20);
    op(0, 0, 1, 32'h0, 4);
    qa.push_back(32'h10);
    op(0, 0, 1, 32'h0, 4);
    chk("empty_after", 32'(ifa.o_empty), 32'd1);
    chk("topv_empty", 32'(ifa.o_top_valid), 32'd0);

    // Fill to capacity, then an ignored enqueue.
    reset_a();
    for (int i = 1; i <= 7; i++) op(0, 1, 0, 32'(i), 4);
    chk("full", 32'(ifa.o_full), 32'd1);
    chk("count_7", 32'(ifa.o_count), 32'd7);
    chk("top_7", ifa.o_top, 32'h7);
    op(0, 1, 0, 32'h99, 0);
    chk("count_7_ign", 32'(ifa.o_count), 32'd7);
    chk("top_7_ign", ifa.o_top, 32'h7);

    // Dequeue when empty.
    reset_a();
    op(0, 0, 1, 32'h0, 0);
    chk("empty_deq_count", 32'(ifa.o_count), 32'd0);
    chk("empty_deq_busy", 32'(ifa.o_busy), 32'd0);

    // Replace on {0x40,0x20,0x30}.
    op(0, 1, 0, 32'h40, 4);
    op(0, 1, 0, 32'h20, 4);
    op(0, 1, 0, 32'h30, 4);
    qa.push_back(32'h40);
    op(0, 1, 1, 32'h05, 4);
    chk("repl_top", ifa.o_top, 32'h30);
    chk("repl_count", 32'(ifa.o_count), 32'd3);
    qa.push_back(32'h30);
    op(0, 0, 1, 32'h0, 4);
    qa.push_back(32'h20);
    op(0, 0, 1, 32'h0, 4);
    qa.push_back(32'h05);
    op(0, 0, 1, 32'h0, 4);

    // Equal keys and a request issued while busy.
    reset_a();
    @(negedge clk);
    drive(0, 1, 0, 32'h10);
    @(negedge clk);
    drive(0, 1, 0, 32'h99);
    chk("busy_high", 32'(ifa.o_busy), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 32'h0);
    wait_idle(0, lat);
    chk("busy_ign_count", 32'(ifa.o_count), 32'd1);
    chk("busy_ign_top", ifa.o_top, 32'h10);
    op(0, 1, 0, 32'h10, 4);
    op(0, 1, 0, 32'h10, 4);
    chk("tie_count", 32'(ifa.o_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      qa.push_back(32'h10);
      op(0, 0, 1, 32'h0, 4);
    end

    // Min heap ordering.
    op(1, 1, 0, 32'h30, 4);
    op(1, 1, 0, 32'h10, 4);
    op(1, 1, 0, 32'h20, 4);
    chk("min_top", ifb.o_top, 32'h10);
    qb.push_back(32'h10);
    op(1, 0, 1, 32'h0, 4);
    qb.push_back(32'h20);
    op(1, 0, 1, 32'h0, 4);
    qb.push_back(32'h30);
    op(1, 0, 1, 32'h0, 4);

    // Reset mid-sort with a concurrent request.
    @(negedge clk);
    drive(1, 1, 0, 32'h55);
    @(negedge clk);
    drive(1, 1, 0, 32'h66);
    rst_b = 1'b1;
    chk("pre_rst_busy", 32'(ifb.o_busy), 32'd1);
    chk("pre_rst_top", ifb.o_top, 32'h55);
    @(negedge clk);
    rst_b = 1'b0;
    drive(1, 0, 0, 32'h0);
    chk("mid_rst_count", 32'(ifb.o_count), 32'd0);
    chk("mid_rst_busy", 32'(ifb.o_busy), 32'd0);
    chk("mid_rst_topv", 32'(ifb.o_top_valid), 32'd0);
    chk("mid_rst_top", ifb.o_top, 32'h0);
    chk("mid_rst_empty", 32'(ifb.o_empty), 32'd1);
    chk("mid_rst_full", 32'(ifb.o_full), 32'd0);
    chk("mid_rst_deqv", 32'(ifb.o_dequeue_valid), 32'd0);
    chk("mid_rst_deqval", ifb.o_dequeue_value, 32'h0);

    // Reset wins over a request presented in idle.
    @(negedge clk);
    rst_b = 1'b1;
    drive(1, 1, 0, 32'h77);
    @(negedge clk);
    rst_b = 1'b0;
    drive(1, 0, 0, 32'h0);
    chk("rst_prec_count", 32'(ifb.o_count), 32'd0);
    chk("rst_prec_busy", 32'(ifb.o_busy), 32'd0);

    repeat (3) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
